// File: rtl/reorder_buffer.sv
// reorder_buffer: 2-wide in-order retire stage with free-pool return.
// Define ROB_DUAL_RETIRE_EN to allow two retirements per cycle.
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int PREG_W = 6,
    parameter int TAG_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc1_valid,
    input  logic              alloc2_valid,
    input  logic [PREG_W-1:0] alloc1_old_pd,
    input  logic [PREG_W-1:0] alloc2_old_pd,
    input  logic [7:0]        alloc1_pc,
    input  logic [7:0]        alloc2_pc,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc1_tag,
    output logic [TAG_W-1:0]  alloc2_tag,
    input  logic              cmpl1_valid,
    input  logic              cmpl2_valid,
    input  logic [TAG_W-1:0]  cmpl1_tag,
    input  logic [TAG_W-1:0]  cmpl2_tag,
    output logic              retire1f,
    output logic              retire2f,
    output logic [PREG_W-1:0] retire1reg,
    output logic [PREG_W-1:0] retire2reg,
    output logic [1:0]        retire_cnt,
    output logic [7:0]        retire1_pc,
    output logic [7:0]        retire2_pc,
    output logic [TAG_W:0]    count,
    output logic              err
);

    localparam logic [TAG_W:0] READY_LIM = (TAG_W+1)'(DEPTH - 2);

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  done_q;
    logic [PREG_W-1:0] old_pd_q [DEPTH];
    logic [7:0]        pc_q     [DEPTH];

    logic [TAG_W-1:0]  head_q;
    logic [TAG_W-1:0]  tail_q;
    logic [TAG_W:0]    count_q;
    logic              err_q;

    logic [TAG_W-1:0]  tail_p1;
    logic              alloc_ok;
    logic              alloc2_ok;
    logic              alloc_bad;
    logic              cmpl1_ok;
    logic              cmpl2_ok;
    logic              cmpl_bad;
    logic              r1;
    logic              r2;
    logic [1:0]        n_alloc;
    logic [1:0]        n_ret;

`ifdef ROB_DUAL_RETIRE_EN
    logic [TAG_W-1:0]  head_p1;
`endif

    assign alloc_ready = (count_q <= READY_LIM);
    assign alloc1_tag  = tail_q;
    assign alloc2_tag  = tail_p1;
    assign count       = count_q;
    assign err         = err_q;

    // Allocation, completion and retire-eligibility decode on pre-edge state
    always_comb begin
        tail_p1   = tail_q + TAG_W'(1);
        alloc_ok  = alloc_ready && alloc1_valid;
        alloc2_ok = alloc_ok && alloc2_valid;
        alloc_bad = ((alloc1_valid || alloc2_valid) && !alloc_ready)
                  || (alloc2_valid && !alloc1_valid);
        n_alloc   = {1'b0, alloc_ok} + {1'b0, alloc2_ok};
        cmpl1_ok  = cmpl1_valid && valid_q[cmpl1_tag];
        cmpl2_ok  = cmpl2_valid && valid_q[cmpl2_tag];
        cmpl_bad  = (cmpl1_valid && !valid_q[cmpl1_tag])
                  || (cmpl2_valid && !valid_q[cmpl2_tag]);
        r1        = valid_q[head_q] && done_q[head_q];
`ifdef ROB_DUAL_RETIRE_EN
        head_p1   = head_q + TAG_W'(1);
        r2        = r1 && valid_q[head_p1] && done_q[head_p1];
`else
        r2        = 1'b0;
`endif
        n_ret     = {1'b0, r1} + {1'b0, r2};
    end

    // Entry array: completion marks done, retire frees, allocate fills
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            done_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                old_pd_q[i] <= '0;
                pc_q[i]     <= '0;
            end
        end else begin
            if (cmpl1_ok) begin
                done_q[cmpl1_tag] <= 1'b1;
            end
            if (cmpl2_ok) begin
                done_q[cmpl2_tag] <= 1'b1;
            end
            if (r1) begin
                valid_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
            end
`ifdef ROB_DUAL_RETIRE_EN
            if (r2) begin
                valid_q[head_p1] <= 1'b0;
                done_q[head_p1]  <= 1'b0;
            end
`endif
            if (alloc_ok) begin
                valid_q[tail_q]  <= 1'b1;
                done_q[tail_q]   <= 1'b0;
                old_pd_q[tail_q] <= alloc1_old_pd;
                pc_q[tail_q]     <= alloc1_pc;
            end
            if (alloc2_ok) begin
                valid_q[tail_p1]  <= 1'b1;
                done_q[tail_p1]   <= 1'b0;
                old_pd_q[tail_p1] <= alloc2_old_pd;
                pc_q[tail_p1]     <= alloc2_pc;
            end
        end
    end

    // Head/tail pointers and occupancy; pointers wrap by natural overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + TAG_W'(n_ret);
            tail_q  <= tail_q + TAG_W'(n_alloc);
            count_q <= count_q + (TAG_W+1)'(n_alloc)
                     - (TAG_W+1)'(n_ret);
        end
    end

    // Sticky protocol-violation flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (alloc_bad || cmpl_bad) begin
            err_q <= 1'b1;
        end
    end

    // Slot 1 free-pool return; PC holds the last retired value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire1f   <= 1'b0;
            retire1reg <= '0;
            retire1_pc <= '0;
            retire_cnt <= '0;
        end else begin
            retire_cnt <= n_ret;
            retire1f   <= r1 && (old_pd_q[head_q] != '0);
            retire1reg <= r1 ? old_pd_q[head_q] : '0;
            if (r1) begin
                retire1_pc <= pc_q[head_q];
            end
        end
    end

`ifdef ROB_DUAL_RETIRE_EN
    // Slot 2 free-pool return; PC holds the last retired value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire2f   <= 1'b0;
            retire2reg <= '0;
            retire2_pc <= '0;
        end else begin
            retire2f   <= r2 && (old_pd_q[head_p1] != '0);
            retire2reg <= r2 ? old_pd_q[head_p1] : '0;
            if (r2) begin
                retire2_pc <= pc_q[head_p1];
            end
        end
    end
`else
    assign retire2f   = 1'b0;
    assign retire2reg = '0;
    assign retire2_pc = '0;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: scoreboard bench for reorder_buffer.
// Honours ROB_DUAL_RETIRE_EN for retire-width expectations.
module tb_reorder_buffer;

    logic       clk;
    logic       rst_n;
    logic       alloc1_valid, alloc2_valid;
    logic [5:0] alloc1_old_pd, alloc2_old_pd;
    logic [7:0] alloc1_pc, alloc2_pc;
    logic       alloc_ready;
    logic [3:0] alloc1_tag, alloc2_tag;
    logic       cmpl1_valid, cmpl2_valid;
    logic [3:0] cmpl1_tag, cmpl2_tag;
    logic       retire1f, retire2f;
    logic [5:0] retire1reg, retire2reg;
    logic [1:0] retire_cnt;
    logic [7:0] retire1_pc, retire2_pc;
    logic [4:0] count;
    logic       err;

    typedef struct {
        logic [5:0] pd;
        logic [7:0] pc;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   failures;
    int   tail_m;

    reorder_buffer #(.DEPTH(16), .PREG_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc1_valid(alloc1_valid), .alloc2_valid(alloc2_valid),
        .alloc1_old_pd(alloc1_old_pd), .alloc2_old_pd(alloc2_old_pd),
        .alloc1_pc(alloc1_pc), .alloc2_pc(alloc2_pc),
        .alloc_ready(alloc_ready),
        .alloc1_tag(alloc1_tag), .alloc2_tag(alloc2_tag),
        .cmpl1_valid(cmpl1_valid), .cmpl2_valid(cmpl2_valid),
        .cmpl1_tag(cmpl1_tag), .cmpl2_tag(cmpl2_tag),
        .retire1f(retire1f), .retire2f(retire2f),
        .retire1reg(retire1reg), .retire2reg(retire2reg),
        .retire_cnt(retire_cnt),
        .retire1_pc(retire1_pc), .retire2_pc(retire2_pc),
        .count(count), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic check_slot(input int s, input logic f,
                              input logic [5:0] r, input logic [7:0] pc);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_retire slot%0d actual_pc=%0h reg=%0d expected=none",
                     s, pc, r);
        end else begin
            e = sb.pop_front();
            chk($sformatf("ret%0d_reg", s), 32'(r), 32'(e.pd));
            chk($sformatf("ret%0d_pc", s), 32'(pc), 32'(e.pc));
            chk($sformatf("ret%0d_f", s), 32'(f), 32'(e.pd != 6'd0));
        end
    endtask

    // Monitor: pop expected retirements in program order
    always @(negedge clk) begin
        if (rst_n) begin
            if (retire_cnt != 2'd0)
                check_slot(1, retire1f, retire1reg, retire1_pc);
            if (retire_cnt == 2'd2)
                check_slot(2, retire2f, retire2reg, retire2_pc);
            if (retire_cnt == 2'd0)
                chk("idle_f", {30'd0, retire1f, retire2f}, 32'd0);
`ifndef ROB_DUAL_RETIRE_EN
            chk("single_slot2",
                {16'd0, retire_cnt[1], retire2f, retire2reg, retire2_pc}, 32'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        alloc1_valid  = 1'b0;
        alloc2_valid  = 1'b0;
        alloc1_old_pd = '0;
        alloc2_old_pd = '0;
        alloc1_pc     = '0;
        alloc2_pc     = '0;
        cmpl1_valid   = 1'b0;
        cmpl2_valid   = 1'b0;
        cmpl1_tag     = '0;
        cmpl2_tag     = '0;
    endtask

    task automatic alloc_pair(input logic [5:0] p1, input logic [7:0] c1,
                              input logic [5:0] p2, input logic [7:0] c2);
        exp_t e;
        chk("tag1", 32'(alloc1_tag), 32'(tail_m));
        chk("tag2", 32'(alloc2_tag), 32'((tail_m + 1) & 15));
        alloc1_valid  = 1'b1;
        alloc2_valid  = 1'b1;
        alloc1_old_pd = p1;
        alloc2_old_pd = p2;
        alloc1_pc     = c1;
        alloc2_pc     = c2;
        e.pd = p1; e.pc = c1; sb.push_back(e);
        e.pd = p2; e.pc = c2; sb.push_back(e);
        tail_m = (tail_m + 2) & 15;
    endtask

    task automatic alloc_one(input logic [5:0] p1, input logic [7:0] c1);
        exp_t e;
        chk("tag1", 32'(alloc1_tag), 32'(tail_m));
        alloc1_valid  = 1'b1;
        alloc1_old_pd = p1;
        alloc1_pc     = c1;
        e.pd = p1; e.pc = c1; sb.push_back(e);
        tail_m = (tail_m + 1) & 15;
    endtask

    task automatic cmpl(input bit v1, input int t1, input bit v2, input int t2);
        cmpl1_valid = v1;
        cmpl1_tag   = 4'(t1);
        cmpl2_valid = v2;
        cmpl2_tag   = 4'(t2);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (count != 5'd0 && n < 200) begin
            tick();
            n++;
        end
        chk({nm, "_count"}, 32'(count), 32'd0);
        @(negedge clk);
        #1;
        chk({nm, "_sb"}, 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        sb.delete();
        clear_in();
        tail_m = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int sent;
        int cyc;
        int cq[$];
        checks   = 0;
        failures = 0;
        tail_m   = 0;
        clear_in();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("rst_ready", 32'(alloc_ready), 32'd1);
        chk("rst_tag1", 32'(alloc1_tag), 32'd0);
        chk("rst_tag2", 32'(alloc2_tag), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cnt", 32'(retire_cnt), 32'd0);
        chk("rst_ret", {2'd0, retire1f, retire1reg, retire1_pc,
                        retire2f, retire2reg, retire2_pc}, 32'd0);

        // basic pair: 33/34, min latency
        alloc_pair(6'd33, 8'h10, 6'd34, 8'h11);
        tick();
        clear_in();
        chk("t1_count_e0", 32'(count), 32'd2);
        cmpl(1, 0, 1, 1);
        tick();
        clear_in();
        chk("t1_cnt_e1", 32'(retire_cnt), 32'd0);
        chk("t1_count_e1", 32'(count), 32'd2);
        tick();
`ifdef ROB_DUAL_RETIRE_EN
        chk("t1_cnt_e2", 32'(retire_cnt), 32'd2);
        chk("t1_count_e2", 32'(count), 32'd0);
`else
        chk("t1_cnt_e2", 32'(retire_cnt), 32'd1);
        chk("t1_count_e2", 32'(count), 32'd1);
        tick();
        chk("t1_cnt_e3", 32'(retire_cnt), 32'd1);
        chk("t1_count_e3", 32'(count), 32'd0);
`endif
        tick();
        chk("t1_idle", 32'(retire_cnt), 32'd0);

        // out-of-order completion must not retire early
        alloc_pair(6'd5, 8'h20, 6'd6, 8'h21);
        tick();
        clear_in();
        cmpl(1, 3, 0, 0);
        tick();
        clear_in();
        tick();
        tick();
        chk("t2_hold_cnt", 32'(retire_cnt), 32'd0);
        chk("t2_hold_count", 32'(count), 32'd2);
        cmpl(1, 2, 0, 0);
        tick();
        clear_in();
        tick();
`ifdef ROB_DUAL_RETIRE_EN
        chk("t2_cnt", 32'(retire_cnt), 32'd2);
        chk("t2_count", 32'(count), 32'd0);
`else
        chk("t2_cnt", 32'(retire_cnt), 32'd1);
        chk("t2_count", 32'(count), 32'd1);
        tick();
        chk("t2_cnt_b", 32'(retire_cnt), 32'd1);
        chk("t2_count_b", 32'(count), 32'd0);
`endif

        // no-destination instruction: retires without free pulse
        alloc_one(6'd0, 8'h40);
        tick();
        clear_in();
        cmpl(1, 4, 0, 0);
        tick();
        clear_in();
        tick();
        chk("t5_cnt", 32'(retire_cnt), 32'd1);
        chk("t5_f", 32'(retire1f), 32'd0);
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_err", 32'(err), 32'd0);

        // 40 pairs streamed through, tags wrap
        sent = 0;
        cyc  = 0;
        while ((sent < 40 || cq.size() != 0) && cyc < 400) begin
            clear_in();
            if (cq.size() != 0) begin
                cmpl1_valid = 1'b1;
                cmpl1_tag   = 4'(cq.pop_front());
            end
            if (cq.size() != 0) begin
                cmpl2_valid = 1'b1;
                cmpl2_tag   = 4'(cq.pop_front());
            end
            if (sent < 40 && alloc_ready) begin
                cq.push_back(tail_m);
                cq.push_back((tail_m + 1) & 15);
                alloc_pair(6'((2 * sent) % 63 + 1), 8'(8'h80 + 2 * sent),
                           6'((2 * sent + 1) % 63 + 1), 8'(8'h81 + 2 * sent));
                sent++;
            end
            tick();
            cyc++;
        end
        clear_in();
        chk("t4_sent", 32'(sent), 32'd40);
        drain("t4");
        chk("t4_err", 32'(err), 32'd0);

        // fill to DEPTH, overflow drop, ready re-raise
        first = tail_m;
        for (int p = 0; p < 8; p++) begin
            chk("t3_ready", 32'(alloc_ready), 32'd1);
            alloc_pair(6'(40 + 2 * p), 8'(8'hC0 + 2 * p),
                       6'(41 + 2 * p), 8'(8'hC1 + 2 * p));
            tick();
            clear_in();
        end
        chk("t3_full_count", 32'(count), 32'd16);
        chk("t3_full_ready", 32'(alloc_ready), 32'd0);
        chk("t3_err_pre", 32'(err), 32'd0);
        alloc1_valid  = 1'b1;
        alloc1_old_pd = 6'd9;
        alloc1_pc     = 8'hEE;
        tick();
        clear_in();
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_drop_count", 32'(count), 32'd16);
        chk("t3_drop_tag", 32'(alloc1_tag), 32'(tail_m));
        cmpl(1, first, 1, (first + 1) & 15);
        tick();
        clear_in();
        tick();
`ifdef ROB_DUAL_RETIRE_EN
        chk("t3_rr_count", 32'(count), 32'd14);
        chk("t3_rr_ready", 32'(alloc_ready), 32'd1);
`else
        chk("t3_r1_count", 32'(count), 32'd15);
        chk("t3_r1_ready", 32'(alloc_ready), 32'd0);
        tick();
        chk("t3_r2_count", 32'(count), 32'd14);
        chk("t3_r2_ready", 32'(alloc_ready), 32'd1);
`endif
        for (int k = 2; k < 16; k += 2) begin
            cmpl(1, (first + k) & 15, 1, (first + k + 1) & 15);
            tick();
        end
        clear_in();
        drain("t3");
        chk("t3_err_sticky", 32'(err), 32'd1);
        do_reset();
        chk("t3_err_clr", 32'(err), 32'd0);

        // mid-operation reset: 5 valid, 3 done
        alloc_pair(6'd1, 8'hD0, 6'd2, 8'hD1);
        tick();
        clear_in();
        alloc_pair(6'd3, 8'hD2, 6'd4, 8'hD3);
        tick();
        clear_in();
        alloc_one(6'd5, 8'hD4);
        tick();
        clear_in();
        cmpl(1, 1, 1, 2);
        tick();
        clear_in();
        cmpl(1, 3, 0, 0);
        tick();
        clear_in();
        chk("t6_count_pre", 32'(count), 32'd5);
        #2;
        rst_n = 1'b0;
        sb.delete();
        tail_m = 0;
        #1;
        chk("t6_async_count", 32'(count), 32'd0);
        chk("t6_async_ready", 32'(alloc_ready), 32'd1);
        chk("t6_async_tags", {24'd0, alloc1_tag, alloc2_tag}, 32'h01);
        chk("t6_async_ret", {retire_cnt, retire1f, retire1reg, retire1_pc,
                             retire2f, retire2reg, retire2_pc}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (4) tick();
        chk("t6_post_cnt", 32'(retire_cnt), 32'd0);
        chk("t6_post_count", 32'(count), 32'd0);
        chk("t6_post_err", 32'(err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
